// File: rtl/axi_wr_arb_pkg.sv
// Shared types and constants for the AXI write-address arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package axi_wr_arb_pkg;

    // Write-transaction phase; the encoding is visible on Write_State_control
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_e;

    // Master identifiers (top bit of AWID_control)
    localparam logic MST_M0 = 1'b0;
    localparam logic MST_M1 = 1'b1;

    // Slave codes (low three bits of AWID_control)
    localparam logic [2:0] SLV_S1    = 3'd1;
    localparam logic [2:0] SLV_S2    = 3'd2;
    localparam logic [2:0] SLV_S3    = 3'd3;
    localparam logic [2:0] SLV_S4    = 3'd4;
    localparam logic [2:0] DEF_SLAVE = 3'd5;

    // AWID_control value whenever no transaction is owned
    localparam logic [3:0] AWID_NONE = 4'hF;

    // Writable address map, inclusive limits
    localparam logic [31:0] S1_BASE  = 32'h0001_0000;
    localparam logic [31:0] S1_LIMIT = 32'h0001_FFFF;
    localparam logic [31:0] S2_BASE  = 32'h0002_0000;
    localparam logic [31:0] S2_LIMIT = 32'h0002_FFFF;
    localparam logic [31:0] S3_BASE  = 32'h1000_0000;
    localparam logic [31:0] S3_LIMIT = 32'h1000_03FF;
    localparam logic [31:0] S4_BASE  = 32'h2000_0000;
    localparam logic [31:0] S4_LIMIT = 32'h201F_FFFF;

    // Inclusive range test used by the decoder
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] limit);
        return (addr >= base) && (addr <= limit);
    endfunction

endpackage

// File: rtl/axi_write_arbiter_if.sv
// Bundle of master/slave handshake lines and arbiter control outputs.
// Latency: n/a (wiring only).
// Backpressure: carries the AW/W/B ready/valid lines unchanged.
interface axi_write_arbiter_if #(
    parameter int ADDR_W = 32
);

    // Master write-address channel
    logic              AWVALID_M0;
    logic              AWVALID_M1;
    logic [ADDR_W-1:0] AWADDR_M0;
    logic [ADDR_W-1:0] AWADDR_M1;

    // Slave address ready
    logic              AWREADY_S1;
    logic              AWREADY_S2;
    logic              AWREADY_S3;
    logic              AWREADY_S4;

    // Master write data
    logic              WVALID_M0;
    logic              WVALID_M1;
    logic              WLAST_M0;
    logic              WLAST_M1;

    // Slave data ready
    logic              WREADY_S1;
    logic              WREADY_S2;
    logic              WREADY_S3;
    logic              WREADY_S4;

    // Write response
    logic              BVALID_S1;
    logic              BVALID_S2;
    logic              BVALID_S3;
    logic              BVALID_S4;
    logic              BREADY_M0;
    logic              BREADY_M1;

    // Arbiter control outputs
    logic [1:0]        Write_State_control;
    logic [3:0]        AWID_control;
    logic              DEF_AWREADY;
    logic              DEF_WREADY;
    logic              DEF_BVALID;
    logic              timeout_err;

    // Arbiter view
    modport slave (
        input  AWVALID_M0, AWVALID_M1, AWADDR_M0, AWADDR_M1,
        input  AWREADY_S1, AWREADY_S2, AWREADY_S3, AWREADY_S4,
        input  WVALID_M0, WVALID_M1, WLAST_M0, WLAST_M1,
        input  WREADY_S1, WREADY_S2, WREADY_S3, WREADY_S4,
        input  BVALID_S1, BVALID_S2, BVALID_S3, BVALID_S4,
        input  BREADY_M0, BREADY_M1,
        output Write_State_control, AWID_control,
        output DEF_AWREADY, DEF_WREADY, DEF_BVALID, timeout_err
    );

    // Surrounding interconnect view
    modport master (
        output AWVALID_M0, AWVALID_M1, AWADDR_M0, AWADDR_M1,
        output AWREADY_S1, AWREADY_S2, AWREADY_S3, AWREADY_S4,
        output WVALID_M0, WVALID_M1, WLAST_M0, WLAST_M1,
        output WREADY_S1, WREADY_S2, WREADY_S3, WREADY_S4,
        output BVALID_S1, BVALID_S2, BVALID_S3, BVALID_S4,
        output BREADY_M0, BREADY_M1,
        input  Write_State_control, AWID_control,
        input  DEF_AWREADY, DEF_WREADY, DEF_BVALID, timeout_err
    );

endinterface

// File: rtl/axi_wr_addr_decoder.sv
// Maps a write address onto a slave code; unmapped and ROM space go to the default slave.
// Latency: purely combinational.
// Backpressure: none.
module axi_wr_addr_decoder
    import axi_wr_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [2:0]        slave
);

    logic [31:0] addr32;

    assign addr32 = 32'(addr);

    // First matching window wins; the windows do not overlap
    always_comb begin
        slave = DEF_SLAVE;
        if (in_range(addr32, S1_BASE, S1_LIMIT)) begin
            slave = SLV_S1;
        end else if (in_range(addr32, S2_BASE, S2_LIMIT)) begin
            slave = SLV_S2;
        end else if (in_range(addr32, S3_BASE, S3_LIMIT)) begin
            slave = SLV_S3;
        end else if (in_range(addr32, S4_BASE, S4_LIMIT)) begin
            slave = SLV_S4;
        end
    end

endmodule

// File: rtl/axi_write_arbiter.sv
// Round-robin AW arbiter for M0/M1 that tracks one write through ADDR/DATA/RESP and hosts a default slave.
// Latency: one cycle from AWVALID to grant (ADDR); one phase per handshake thereafter.
// Backpressure: waits on selected slave ready/valid and master BREADY; a stalled phase is aborted after 2^TIMEOUT_W-1 cycles.
module axi_write_arbiter
    import axi_wr_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic               ACLK,
    input  logic               ARESET,
    axi_write_arbiter_if.slave bus
);

    // A zero-width timeout still needs a one-bit counter to time DEF_AWREADY
    localparam int               CNT_W      = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic             TIMEOUT_EN = (TIMEOUT_W > 0);

    wr_state_e        state_q, state_d;
    logic [3:0]       awid_q, awid_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             def_bvalid_q, def_bvalid_d;

    logic              any_awvalid;
    logic              gnt_m;
    logic [ADDR_W-1:0] gnt_addr;
    logic [2:0]        gnt_slv;

    logic       own_m;
    logic [2:0] own_slv;
    logic       own_is_def;
    logic       own_awvalid, own_wvalid, own_wlast, own_bready;
    logic       sel_awready, sel_wready, sel_bvalid;
    logic       def_awready, def_wready;
    logic       stall_expired;

    assign any_awvalid = bus.AWVALID_M0 | bus.AWVALID_M1;

    // Candidate grant: a lone requester wins, otherwise the priority pointer decides
    always_comb begin
        gnt_m = ptr_q;
        if (bus.AWVALID_M0 && !bus.AWVALID_M1) begin
            gnt_m = MST_M0;
        end else if (!bus.AWVALID_M0 && bus.AWVALID_M1) begin
            gnt_m = MST_M1;
        end
        gnt_addr = (gnt_m == MST_M1) ? bus.AWADDR_M1 : bus.AWADDR_M0;
    end

    axi_wr_addr_decoder #(
        .ADDR_W (ADDR_W)
    ) u_addr_decoder (
        .addr  (gnt_addr),
        .slave (gnt_slv)
    );

    // Owner of the transaction in flight, taken from the latched control code
    assign own_m      = awid_q[3];
    assign own_slv    = awid_q[2:0];
    assign own_is_def = (own_slv == DEF_SLAVE);

    // Steer the owning master's handshake lines
    always_comb begin
        own_awvalid = bus.AWVALID_M0;
        own_wvalid  = bus.WVALID_M0;
        own_wlast   = bus.WLAST_M0;
        own_bready  = bus.BREADY_M0;
        if (own_m == MST_M1) begin
            own_awvalid = bus.AWVALID_M1;
            own_wvalid  = bus.WVALID_M1;
            own_wlast   = bus.WLAST_M1;
            own_bready  = bus.BREADY_M1;
        end
    end

    // Default slave accepts the address only in the first ADDR cycle, data throughout DATA
    assign def_awready = own_is_def && (state_q == ST_ADDR) && (cnt_q == '0);
    assign def_wready  = own_is_def && (state_q == ST_DATA);

    // Steer the selected slave's handshake lines, default slave included
    always_comb begin
        sel_awready = 1'b0;
        sel_wready  = 1'b0;
        sel_bvalid  = 1'b0;
        case (own_slv)
            SLV_S1: begin
                sel_awready = bus.AWREADY_S1;
                sel_wready  = bus.WREADY_S1;
                sel_bvalid  = bus.BVALID_S1;
            end
            SLV_S2: begin
                sel_awready = bus.AWREADY_S2;
                sel_wready  = bus.WREADY_S2;
                sel_bvalid  = bus.BVALID_S2;
            end
            SLV_S3: begin
                sel_awready = bus.AWREADY_S3;
                sel_wready  = bus.WREADY_S3;
                sel_bvalid  = bus.BVALID_S3;
            end
            SLV_S4: begin
                sel_awready = bus.AWREADY_S4;
                sel_wready  = bus.WREADY_S4;
                sel_bvalid  = bus.BVALID_S4;
            end
            DEF_SLAVE: begin
                sel_awready = def_awready;
                sel_wready  = def_wready;
                sel_bvalid  = def_bvalid_q;
            end
            default: begin
            end
        endcase
    end

    // The counter never passes CNT_MAX because expiry forces IDLE on the next edge
    assign stall_expired = TIMEOUT_EN && (state_q != ST_IDLE) && (cnt_q == CNT_MAX);

    // Phase sequencing, grant latch, pointer update, stall counting
    always_comb begin
        state_d = state_q;
        awid_d  = awid_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (any_awvalid) begin
                    state_d = ST_ADDR;
                    awid_d  = {gnt_m, gnt_slv};
                end
            end
            ST_ADDR: begin
                if (own_awvalid && sel_awready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (own_wvalid && sel_wready && own_wlast) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (sel_bvalid && own_bready) begin
                    state_d = ST_IDLE;
                    awid_d  = AWID_NONE;
                    ptr_d   = ~own_m;
                end
            end
            default: begin
                state_d = ST_IDLE;
                awid_d  = AWID_NONE;
            end
        endcase

        // A stuck phase is abandoned and the other master gets first chance next
        if (stall_expired) begin
            state_d = ST_IDLE;
            awid_d  = AWID_NONE;
            ptr_d   = ~ptr_q;
        end

        cnt_d = cnt_q;
        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Default-slave response is presented for the whole RESP phase it owns
        def_bvalid_d = own_is_def && (state_d == ST_RESP);
    end

    // State registers with synchronous reset; reset abandons any transaction in flight
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= ST_IDLE;
            awid_q       <= AWID_NONE;
            ptr_q        <= MST_M0;
            cnt_q        <= '0;
            def_bvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            awid_q       <= awid_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            def_bvalid_q <= def_bvalid_d;
        end
    end

    assign bus.Write_State_control = state_q;
    assign bus.AWID_control        = awid_q;
    assign bus.DEF_AWREADY         = def_awready;
    assign bus.DEF_WREADY          = def_wready;
    assign bus.DEF_BVALID          = def_bvalid_q;
    assign bus.timeout_err         = stall_expired;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Randomized and directed bench for axi_write_arbiter against a transaction-level reference model.
// Latency: one model step per clock.
// Backpressure: bench drives all ready/valid lines directly.
module tb_axi_write_arbiter;

    localparam int TIMEOUT_W   = 4;
    localparam int STALL_LIMIT = (1 << TIMEOUT_W) - 1;

    logic ACLK;
    logic ARESET;

    axi_write_arbiter_if #(.ADDR_W(32)) bif ();

    axi_write_arbiter #(
        .ADDR_W    (32),
        .TIMEOUT_W (TIMEOUT_W)
    ) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bif)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_err = 0;

    // Stimulus state (indexed by master 0/1 or slave 0..3 = S1..S4)
    bit          rst_i;
    bit          awv [2];
    logic [31:0] awaddr [2];
    bit          wv [2];
    bit          wl [2];
    bit          br [2];
    bit          awr [4];
    bit          wr [4];
    bit          bv [4];

    // Reference model state
    int m_phase;
    int m_owner;
    int m_target;
    int m_ptr;
    int m_stall;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_decode(input logic [31:0] a);
        logic [31:0] lo [4];
        logic [31:0] hi [4];
        lo = '{32'h0001_0000, 32'h0002_0000, 32'h1000_0000, 32'h2000_0000};
        hi = '{32'h0001_FFFF, 32'h0002_FFFF, 32'h1000_03FF, 32'h201F_FFFF};
        for (int i = 0; i < 4; i++) begin
            if (a >= lo[i] && a <= hi[i]) return i + 1;
        end
        return 5;
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] pool [16];
        pool = '{32'h0000_0000, 32'h0000_FFFF, 32'h0001_0000, 32'h0001_FFFF,
                 32'h0002_0000, 32'h0002_FFFF, 32'h0003_0000, 32'h0FFF_FFFF,
                 32'h1000_0000, 32'h1000_03FF, 32'h1000_0400, 32'h2000_0000,
                 32'h201F_FFFF, 32'h2020_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        pool[15] = $urandom;
        return pool[$urandom_range(0, 15)];
    endfunction

    task automatic clear_inputs();
        rst_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            awv[i] = 1'b0; awaddr[i] = '0; wv[i] = 1'b0; wl[i] = 1'b0; br[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            awr[i] = 1'b0; wr[i] = 1'b0; bv[i] = 1'b0;
        end
    endtask

    task automatic drive();
        ARESET         = rst_i;
        bif.AWVALID_M0 = awv[0];    bif.AWVALID_M1 = awv[1];
        bif.AWADDR_M0  = awaddr[0]; bif.AWADDR_M1  = awaddr[1];
        bif.WVALID_M0  = wv[0];     bif.WVALID_M1  = wv[1];
        bif.WLAST_M0   = wl[0];     bif.WLAST_M1   = wl[1];
        bif.BREADY_M0  = br[0];     bif.BREADY_M1  = br[1];
        bif.AWREADY_S1 = awr[0]; bif.AWREADY_S2 = awr[1]; bif.AWREADY_S3 = awr[2]; bif.AWREADY_S4 = awr[3];
        bif.WREADY_S1  = wr[0];  bif.WREADY_S2  = wr[1];  bif.WREADY_S3  = wr[2];  bif.WREADY_S4  = wr[3];
        bif.BVALID_S1  = bv[0];  bif.BVALID_S2  = bv[1];  bif.BVALID_S3  = bv[2];  bif.BVALID_S4  = bv[3];
    endtask

    // One clock of the reference: apply the specification's phase rules to the sampled inputs
    task automatic model_step();
        int  np;
        bit  tgt_awready, tgt_wready, tgt_bvalid;
        if (rst_i) begin
            m_phase = 0; m_ptr = 0; m_stall = 0; m_owner = 0; m_target = 0;
            return;
        end
        tgt_awready = (m_target == 5) ? (m_stall == 0) : (m_target >= 1 && awr[m_target - 1]);
        tgt_wready  = (m_target == 5) ? 1'b1 : (m_target >= 1 && wr[m_target - 1]);
        tgt_bvalid  = (m_target == 5) ? 1'b1 : (m_target >= 1 && bv[m_target - 1]);
        np = m_phase;
        if (m_phase != 0 && m_stall == STALL_LIMIT) begin
            np    = 0;
            m_ptr = 1 - m_ptr;
        end else begin
            case (m_phase)
                0: if (awv[0] || awv[1]) begin
                       m_owner  = (awv[0] && awv[1]) ? m_ptr : (awv[1] ? 1 : 0);
                       m_target = ref_decode(awaddr[m_owner]);
                       np       = 1;
                   end
                1: if (awv[m_owner] && tgt_awready) np = 2;
                2: if (wv[m_owner] && wl[m_owner] && tgt_wready) np = 3;
                3: if (br[m_owner] && tgt_bvalid) begin
                       np    = 0;
                       m_ptr = 1 - m_owner;
                   end
                default: np = 0;
            endcase
        end
        if (np != m_phase || np == 0) m_stall = 0;
        else if (m_stall < STALL_LIMIT) m_stall = m_stall + 1;
        m_phase = np;
    endtask

    // Drive, clock, advance model, then compare every output on the falling edge
    task automatic cycle();
        drive();
        @(posedge ACLK);
        model_step();
        @(negedge ACLK);
        check_eq("state", bif.Write_State_control, m_phase);
        check_eq("awid", bif.AWID_control, (m_phase == 0) ? 15 : m_owner * 8 + m_target);
        check_eq("def_awready", bif.DEF_AWREADY, (m_target == 5 && m_phase == 1 && m_stall == 0));
        check_eq("def_wready", bif.DEF_WREADY, (m_target == 5 && m_phase == 2));
        check_eq("def_bvalid", bif.DEF_BVALID, (m_target == 5 && m_phase == 3));
        check_eq("timeout_err", bif.timeout_err, (m_phase != 0 && m_stall == STALL_LIMIT));
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
    endtask

    initial begin
        m_phase = 0; m_owner = 0; m_target = 0; m_ptr = 0; m_stall = 0;
        do_reset();
        check_eq("rst_state", bif.Write_State_control, 0);
        check_eq("rst_awid", bif.AWID_control, 4'hF);
        check_eq("rst_def", {bif.DEF_AWREADY, bif.DEF_WREADY, bif.DEF_BVALID, bif.timeout_err}, 0);

        // Single 4-beat write M0 -> S2
        awv[0] = 1; awaddr[0] = 32'h0002_0010;
        cycle();
        check_eq("d1_grant_state", bif.Write_State_control, 1);
        check_eq("d1_grant_awid", bif.AWID_control, 4'h2);
        awr[1] = 1;
        cycle();
        check_eq("d1_data_state", bif.Write_State_control, 2);
        awv[0] = 0; awr[1] = 0; wv[0] = 1; wr[1] = 1;
        for (int beat = 1; beat <= 4; beat++) begin
            wl[0] = (beat == 4);
            cycle();
            check_eq("d1_beat_state", bif.Write_State_control, (beat < 4) ? 2 : 3);
            check_eq("d1_beat_awid", bif.AWID_control, 4'h2);
        end
        wv[0] = 0; wl[0] = 0; wr[1] = 0; bv[1] = 1; br[0] = 1;
        cycle();
        check_eq("d1_done_state", bif.Write_State_control, 0);
        check_eq("d1_done_awid", bif.AWID_control, 4'hF);
        bv[1] = 0; br[0] = 0;
        awv[0] = 1; awv[1] = 1; awaddr[0] = 32'h0001_0000; awaddr[1] = 32'h0001_0000;
        cycle();
        check_eq("d1_ptr_m1", bif.AWID_control, 4'h9);

        // Simultaneous requests after reset: M0 first, then M1
        do_reset();
        awv[0] = 1; awv[1] = 1; awaddr[0] = 32'h0001_0000; awaddr[1] = 32'h2000_0000;
        cycle();
        check_eq("d2_first_awid", bif.AWID_control, 4'h1);
        awr[0] = 1;
        cycle();
        awr[0] = 0; wv[0] = 1; wl[0] = 1; wr[0] = 1;
        cycle();
        check_eq("d2_resp_state", bif.Write_State_control, 3);
        wv[0] = 0; wl[0] = 0; wr[0] = 0; bv[0] = 1; br[0] = 1;
        cycle();
        check_eq("d2_no_same_cycle_grant", bif.Write_State_control, 0);
        bv[0] = 0; br[0] = 0;
        cycle();
        check_eq("d2_second_awid", bif.AWID_control, 4'hC);

        // M1 write to ROM served by the default slave
        do_reset();
        awv[1] = 1; awaddr[1] = 32'h0000_0100;
        cycle();
        check_eq("d3_awid", bif.AWID_control, 4'hD);
        check_eq("d3_def_aw_on", bif.DEF_AWREADY, 1);
        cycle();
        check_eq("d3_def_aw_off", bif.DEF_AWREADY, 0);
        check_eq("d3_def_w_on", bif.DEF_WREADY, 1);
        awv[1] = 0; wv[1] = 1;
        cycle();
        check_eq("d3_nonlast_state", bif.Write_State_control, 2);
        wl[1] = 1;
        cycle();
        check_eq("d3_def_b_on", bif.DEF_BVALID, 1);
        check_eq("d3_def_w_off", bif.DEF_WREADY, 0);
        wv[1] = 0; wl[1] = 0;
        cycle();
        cycle();
        check_eq("d3_def_b_held", bif.DEF_BVALID, 1);
        br[1] = 1;
        cycle();
        check_eq("d3_idle_state", bif.Write_State_control, 0);
        check_eq("d3_def_b_off", bif.DEF_BVALID, 0);
        br[1] = 0;

        // Response backpressure from M0 on S4
        awv[0] = 1; awaddr[0] = 32'h2000_0000;
        cycle();
        awr[3] = 1;
        cycle();
        awv[0] = 0; awr[3] = 0; wv[0] = 1; wl[0] = 1; wr[3] = 1;
        cycle();
        wv[0] = 0; wl[0] = 0; wr[3] = 0; bv[3] = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("d4_hold_state", bif.Write_State_control, 3);
            check_eq("d4_hold_awid", bif.AWID_control, 4'h4);
        end
        br[0] = 1;
        cycle();
        check_eq("d4_release_state", bif.Write_State_control, 0);
        bv[3] = 0; br[0] = 0;

        // ADDR-phase timeout on S3
        do_reset();
        awv[0] = 1; awaddr[0] = 32'h1000_0000;
        cycle();
        check_eq("d5_awid", bif.AWID_control, 4'h3);
        awv[0] = 0;
        for (int i = 1; i <= STALL_LIMIT; i++) begin
            cycle();
            check_eq("d5_stall_state", bif.Write_State_control, 1);
            check_eq("d5_timeout_pulse", bif.timeout_err, (i == STALL_LIMIT));
        end
        cycle();
        check_eq("d5_after_state", bif.Write_State_control, 0);
        check_eq("d5_after_awid", bif.AWID_control, 4'hF);
        check_eq("d5_after_pulse", bif.timeout_err, 0);
        awv[0] = 1; awv[1] = 1; awaddr[0] = 32'h0002_0000; awaddr[1] = 32'h0002_0000;
        cycle();
        check_eq("d5_ptr_flipped", bif.AWID_control, 4'hA);

        // Reset in DATA abandons the transaction and restores pointer to M0
        awr[1] = 1;
        cycle();
        check_eq("d6_data_state", bif.Write_State_control, 2);
        awv[0] = 0; awv[1] = 0; awr[1] = 0; rst_i = 1;
        cycle();
        check_eq("d6_rst_state", bif.Write_State_control, 0);
        check_eq("d6_rst_awid", bif.AWID_control, 4'hF);
        check_eq("d6_rst_def", {bif.DEF_AWREADY, bif.DEF_WREADY, bif.DEF_BVALID}, 0);
        rst_i = 0; awv[0] = 1; awv[1] = 1; awaddr[0] = 32'h0001_0000; awaddr[1] = 32'h0001_0000;
        cycle();
        check_eq("d6_ptr_m0", bif.AWID_control, 4'h1);

        // Randomized traffic checked every cycle against the model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            rst_i = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 2; i++) begin
                awv[i] = ($urandom_range(0, 99) < 50);
                if ($urandom_range(0, 3) == 0) awaddr[i] = pick_addr();
                wv[i]  = ($urandom_range(0, 99) < 70);
                wl[i]  = ($urandom_range(0, 99) < 35);
                br[i]  = ($urandom_range(0, 99) < 60);
            end
            for (int s = 0; s < 4; s++) begin
                awr[s] = ($urandom_range(0, 99) < 50);
                wr[s]  = ($urandom_range(0, 99) < 60);
                bv[s]  = ($urandom_range(0, 99) < 50);
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_write_arbiter.md
Name: axi_write_arbiter

Overview:
- Sits upstream of the write response channel in the AXI interconnect.
- Arbitrates AW requests from masters M0/M1 and decodes the granted address to one writable slave: S1 IM, S2 DM, S3 sensor ctrl, S4 DRAM.
- Tracks each transaction through the address, data and response phases. It drives the write-state and AWID-control codes that steer the AW/W/B muxes.
- Contains a built-in default slave that completes writes to unmapped or ROM addresses so the response channel can return DECERR.

Parameters:
- ADDR_W, 32, address width.
- TIMEOUT_W, 8, width of the per-phase stall counter (0 disables the timeout).

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous, active-high reset.
- AWVALID_M0, AWVALID_M1  in  1  master address valid.
- AWADDR_M0, AWADDR_M1  in  ADDR_W  master write address.
- AWREADY_S1..AWREADY_S4  in  1  slave address ready.
- WVALID_M0, WVALID_M1  in  1  master write data valid.
- WLAST_M0, WLAST_M1  in  1  master last beat.
- WREADY_S1..WREADY_S4  in  1  slave data ready.
- BVALID_S1..BVALID_S4  in  1  slave response valid.
- BREADY_M0, BREADY_M1  in  1  master response ready.
- Write_State_control  out  2  current phase: IDLE=0, ADDR=1, DATA=2, RESP=3.
- AWID_control  out  4  {master bit, slave[2:0]}. Slave codes: 1..4 = S1..S4, 5 = default slave. NONE = 4'hF.
- DEF_AWREADY, DEF_WREADY, DEF_BVALID  out  1  default-slave handshake outputs.
- timeout_err  out  1  one-cycle pulse when a phase exceeds its stall limit.

Behaviour:
- Reset values: state IDLE, AWID_control=4'hF, priority pointer=M0, all DEF_* outputs=0, timeout_err=0, stall counter=0. Reset asserted mid-transaction aborts it on that edge with no completion handshake.
- IDLE:
  - If any AWVALID is high, grant one master. With a single requester, grant it. With both, grant the master selected by the priority pointer.
  - Latch {master, decode(AWADDR of granted master)} into AWID_control. Next state is ADDR, one cycle of latency.
  - AWID_control reads NONE throughout IDLE.
- Address decode (inclusive ranges):
  - S1: 0x0001_0000–0x0001_FFFF.
  - S2: 0x0002_0000–0x0002_FFFF.
  - S3: 0x1000_0000–0x1000_03FF.
  - S4: 0x2000_0000–0x201F_FFFF.
  - Anything else, including ROM 0x0000_0000–0x0000_FFFF, decodes to slave code 5 (default slave).
- ADDR: leave to DATA on AWVALID_Mg & sel_AWREADY, where Mg is the granted master and sel is the decoded slave.
- DATA: leave to RESP on WVALID_Mg & sel_WREADY & WLAST_Mg. Non-last beats stay in DATA.
- RESP: leave to IDLE on sel_BVALID & BREADY_Mg. On that cycle, set the priority pointer to the non-granted master (round robin).
- AWID_control is registered and constant from grant until RESP exits. Write_State_control equals the state register.
- Default slave (sel=5):
  - DEF_AWREADY=1 for exactly one cycle when in ADDR.
  - DEF_WREADY=1 throughout DATA.
  - DEF_BVALID is registered: set on the cycle after DATA exits, held until BREADY_Mg, then cleared.
  - For sel≠5, all DEF_* outputs are 0.
- Stall counter:
  - Clears on every state change; increments each cycle in ADDR/DATA/RESP and saturates.
  - When it reaches 2^TIMEOUT_W−1, pulse timeout_err for one cycle and force state to IDLE. AWID_control goes to NONE and the priority pointer flips.
  - Counter is held at 0 in IDLE.
- A new grant is never issued in the same cycle RESP exits; the earliest next grant is the following IDLE cycle.
- AWVALID deasserting in ADDR (protocol violation) does not change state; the stall timeout recovers it.

Decomposition:
- Package axi_wr_arb_pkg holds:
  - State enum (IDLE/ADDR/DATA/RESP).
  - Master/slave code constants, including NONE=4'hF and DEF_SLAVE=3'd5.
  - Address-map base/limit constants.
- Sub-module axi_wr_addr_decoder: purely combinational, maps an address to a 3-bit slave code. It is instantiated once and fed by the granted-master address mux.

Test Plan:
- Single write, M0 to 0x0002_0010: AWREADY_S2 high in ADDR, 4 beats with WLAST on beat 4, BVALID_S2 & BREADY_M0.
  - Expect AWID_control=4'h2 in cycles ADDR..RESP.
  - Expect states 1→2→3→0.
  - Expect pointer=M1 afterwards.
- Simultaneous AWVALID_M0/M1 after reset: M0 granted (AWID_control=4'h1 for address 0x0001_0000). After completion, both still requesting: M1 granted (4'hC for address 0x2000_0000).
- M1 write to 0x0000_0100 (ROM):
  - Expect AWID_control=4'hD.
  - Expect DEF_AWREADY 1-cycle pulse, DEF_WREADY high in DATA.
  - Expect DEF_BVALID high the cycle after WLAST handshake, held until BREADY_M1, then state IDLE.
- BREADY_M0 held low for 5 cycles in RESP with BVALID_S4 high: state stays 3 and AWID_control stays 4'h4; IDLE one cycle after BREADY_M0 rises.
- TIMEOUT_W=4, AWREADY_S3 never asserted: timeout_err pulses after 15 cycles in ADDR, state goes to 0, AWID_control goes to 4'hF.
- ARESET asserted during DATA: next cycle state=0, AWID_control=4'hF, all DEF_* outputs=0, pointer=M0.
